elc3_soc_mul_seq: RTL and testbench

//  Operand sequencer that sits directly upstream of the two-part 16-bit multiply cell
//  (elc3_soc_nios2_qsys_0_mult_cell). It turns one 32x32 request into two cell passes
//  and sums the pass results, giving the low 32 bits of a*b (MUL semantics).
//  - Pass 1: cell computes a*b[15:0] mod 2^32.
//  - Pass 2: cell computes (a[15:0]*b[31:16])<<16 mod 2^32.
//  It also owns the valid/ready handshake toward the requester and the result register.

---
 rtl/elc3_soc_mul_seq.sv | 123 ++++++++++++
 tb/tb_elc3_soc_mul_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elc3_soc_mul_seq.sv
// Two-pass 32x32 MUL operand sequencer feeding the 32x16 multiply cell.
// Optional fast path that skips pass 2 when b[31:16]==0: define MUL_FASTPATH_EN.
module elc3_soc_mul_seq #(
    parameter int unsigned DW       = 32,
    parameter int unsigned CELL_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] mul_src1,
    output logic [DW-1:0] mul_src2,
    input  logic [DW-1:0] cell_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          busy
);

    // The state sequence hard-wires a 32-bit cell with one register stage.
    if (DW != 32 || CELL_LAT != 1) begin : g_cfg_check
        $error("elc3_soc_mul_seq supports only DW=32, CELL_LAT=1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE1,
        S_ISSUE2,
        S_WAIT2,
`ifdef MUL_FASTPATH_EN
        S_WAIT1,
`endif
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = S_ISSUE1;
            end
            S_ISSUE1: begin
`ifdef MUL_FASTPATH_EN
                if (b_q[31:16] == '0) state_nxt = S_WAIT1;
                else                  state_nxt = S_ISSUE2;
`else
                state_nxt = S_ISSUE2;
`endif
            end
            S_ISSUE2: state_nxt = S_WAIT2;
            S_WAIT2:  state_nxt = S_DONE;
`ifdef MUL_FASTPATH_EN
            S_WAIT1:  state_nxt = S_DONE;
`endif
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Pass results land one cycle after their operands are driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q <= in_a;
                        b_q <= in_b;
                    end
                end
                S_ISSUE2: acc <= cell_result;
                S_WAIT2:  acc <= acc + cell_result;
`ifdef MUL_FASTPATH_EN
                S_WAIT1:  acc <= cell_result;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        mul_src1 = '0;
        mul_src2 = '0;
        case (state)
            S_ISSUE1: begin
                mul_src1 = a_q;
                mul_src2 = b_q;
            end
            S_ISSUE2: begin
                mul_src1 = {a_q[15:0], 16'h0000};
                mul_src2 = {16'h0000, b_q[31:16]};
            end
            default: ;
        endcase
    end

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign out_result = (state == S_DONE) ? acc : '0;

endmodule

// File: tb/tb_elc3_soc_mul_seq.sv
// Bench for elc3_soc_mul_seq with a behavioural 32x16 registered multiply cell.
// Scoreboard: expected products queued at accept, compared at the output handshake.
module tb_elc3_soc_mul_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic [31:0] cell_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int total = 0;
    int bad = 0;
    int n_results = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    elc3_soc_mul_seq #(.DW(32), .CELL_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_src1    (mul_src1),
        .mul_src2    (mul_src2),
        .cell_result (cell_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell model: src1 * src2[15:0], one register stage, reset_n = ~reset.
    logic [31:0] cell_q;
    always @(posedge clk or posedge reset) begin
        if (reset) cell_q <= '0;
        else       cell_q <= mul_src1 * {16'h0000, mul_src2[15:0]};
    end
    assign cell_result = cell_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit is_two_pass(input logic [31:0] b);
`ifdef MUL_FASTPATH_EN
        return b[31:16] != 16'h0000;
`else
        return 1'b1;
`endif
    endfunction

    // Compare away from both edges; inputs change on negedge.
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h want none", out_result);
            end else begin
                chk("result", out_result, sb.pop_front());
                n_results++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   {31'b0, in_ready},  32'd1);
        chk({tag, "_out_valid"},  {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_result"}, out_result,         32'd0);
        chk({tag, "_mul_src1"},   mul_src1,           32'd0);
        chk({tag, "_mul_src2"},   mul_src2,           32'd0);
        chk({tag, "_busy"},       {31'b0, busy},      32'd0);
    endtask

    // One request with out_ready high; checks operand sequencing and latency.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int k;
        bit two;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        two      = is_two_pass(b);
        k        = 1;
        chk("pass1_src1", mul_src1, a);
        chk("pass1_src2", mul_src2, b);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 2 && two) begin
                chk("pass2_src1", mul_src1, {a[15:0], 16'h0000});
                chk("pass2_src2", mul_src2, {16'h0000, b[31:16]});
            end
        end
        chk("latency", k, two ? 32'd4 : 32'd3);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t bb[3];
        int   k;
        int   idx;
        int   acc_cyc[3];
        int   base;
        int   ov_cnt;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs.push_back('{32'h00000003, 32'h00000005, 32'h0000000F});
        vecs.push_back('{32'h00010001, 32'h00010001, 32'h00020001});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
        vecs.push_back('{32'h00010000, 32'h00010000, 32'h00000000});
        vecs.push_back('{32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFF9});
        vecs.push_back('{32'h0000FFFF, 32'h00010000, 32'hFFFF0000});
        vecs.push_back('{32'hDEADBEEF, 32'h00000000, 32'h00000000});
        vecs.push_back('{32'h80000000, 32'h00000002, 32'h00000000});
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            vecs.push_back('{ra, rb, ra * rb});
        end

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        foreach (vecs[i]) run_one(vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure: result and valid held while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h0000FFFF;
        in_b      = 32'h0000FFFF;
        chk("bp_accept_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back(32'hFFFE0001);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 6; i++) begin
            chk("bp_out_valid",  {31'b0, out_valid}, 32'd1);
            chk("bp_out_result", out_result,         32'hFFFE0001);
            chk("bp_in_ready",   {31'b0, in_ready},  32'd0);
            @(negedge clk);
        end
        base = n_results;
        out_ready = 1'b1;
        @(negedge clk);
        #3;
        chk("bp_handshakes", n_results - base, 32'd1);
        chk("bp_valid_drop", {31'b0, out_valid}, 32'd0);

        // Back-to-back with in_valid held high.
        bb[0] = '{32'd100,        32'd200,        32'h00004E20};
        bb[1] = '{32'h00010000,   32'h00000003,   32'h00030000};
        bb[2] = '{32'hFFFFFFFE,   32'h00030000,   32'hFFFA0000};
        base = n_results;
        idx = 0;
        for (int cyc = 0; cyc < 60 && !(idx == 3 && sb.size() == 0); cyc++) begin
            @(negedge clk);
            if (idx < 3) begin
                in_valid = 1'b1;
                in_a     = bb[idx].a;
                in_b     = bb[idx].b;
            end else begin
                in_valid = 1'b0;
            end
            chk("b2b_ready_vs_busy",  {31'b0, in_ready & busy},      32'd0);
            chk("b2b_ready_vs_valid", {31'b0, in_ready & out_valid}, 32'd0);
            if (in_valid && in_ready) begin
                sb.push_back(bb[idx].exp);
                acc_cyc[idx] = cyc;
                idx++;
            end
        end
        chk("b2b_accepts", idx, 32'd3);
        for (int i = 1; i < 3; i++)
            chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], is_two_pass(bb[i-1].b) ? 32'd5 : 32'd4);
        @(negedge clk);
        #3;
        chk("b2b_results", n_results - base, 32'd3);

        // Reset in ISSUE2 abandons the request.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'h00001234;
        in_b     = 32'h56780009;
        chk("rst_accept_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_issue2_src2", mul_src2, 32'h00005678);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("rst_no_valid", ov_cnt, 32'd0);
        run_one(32'h00000011, 32'h00000013, 32'h00000143);

        @(negedge clk);
        #3;
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
